psum_tx: RTL
============

# psum_tx

Transmit end of the processing element's partial-sum output path: accepts psum words from the PE datapath and buffers them in a small FIFO. Drives them to the downstream consumer (next PE in the column or the global buffer) over a valid/ready handshake. It absorbs consumer back-pressure so the MAC pipeline stalls only when the buffer is full, and it flags any word lost to a write while full.

## Interface
- DATA_WIDTH, 16, psum word width
- DEPTH, 4, buffer entries; power of two, at least 2
- CNT_WIDTH, $clog2(DEPTH)+1, width of `count`
- clk  input  1  clock; all state updates on the falling edge, matching the PE datapath
- reset_n  input  1  reset, asynchronous and active-low
- clear  input  1  synchronous flush of the buffer and the overflow flag
- in_valid  input  1  producer offers `in_data`
- in_data  input  DATA_WIDTH  psum word from the PE
- in_ready  output  1  buffer can accept a word (not full)
- out_valid  output  1  head word available (not empty)
- out_data  output  DATA_WIDTH  head word
- out_ready  input  1  consumer accepts `out_data`
- count  output  CNT_WIDTH  occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was attempted while full

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready; both are sampled at the falling edge.
- Storage is circular, with write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping DEPTH-1 -> 0. Occupancy is tracked in `count`.
- Push: mem[wp] <= in_data, wp advances, count increments.
- Pop: rp advances, count decrements.
- Push and pop in the same edge (requires 0 < count < DEPTH): both pointers advance and count is unchanged.
- Push attempted while full (in_valid=1, in_ready=0): the word is discarded, overflow sets to 1 and stays set until reset or clear. Storage and pointers are unchanged.
- Pop attempted while empty: ignored, since out_valid=0.
- Empty buffer: no combinational bypass. A word pushed into an empty buffer appears on out_valid after the push edge.
- Full buffer: in_ready=0 even if out_ready=1. There is no pass-through write when full.
- clear=1: wp, rp, count and overflow go to 0 at the edge. It overrides any push or pop in the same cycle, and memory contents are not cleared.
- Output and flag derivation:
  - out_data = mem[rp]; its value is meaningful only while out_valid=1.
  - out_valid = (count != 0).
  - in_ready = (count != DEPTH).
- Async reset (reset_n=0), at any time including mid-transfer, immediately forces:
  - wp, rp, count and overflow to 0, and all mem entries to 0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1, count=0, overflow=0.
  - Any in-flight words are lost.
- The first falling edge after reset_n rises operates normally.

## Timing
- Push-to-output latency is 1 falling edge: a word pushed at edge k gives out_valid=1 and out_data equal to that word after edge k.
- Throughput is 1 word per cycle in and 1 per cycle out simultaneously, in steady state.
- Outputs are functions of registered state only. There is no combinational path from in_valid/in_data/out_ready to any output.
- The handshake holds as follows:
  - out_data and out_valid are stable until popped; they change only at a pop, clear or reset.
  - A producer may hold in_valid across a full period. Its word is lost and overflow is raised, so producers must gate in_valid on in_ready.
- count, in_ready and out_valid update on the same edge as the push or pop that changes them.

## Structure
- Shared package pe_pkg holds the PSUM_WIDTH default (16), PSUM_FIFO_DEPTH default (4), and the count width function.
- The natural sub-module is psum_fifo_mem: DEPTH x DATA_WIDTH register file with one write port (we, waddr, wdata), one asynchronous read port (raddr -> rdata), falling-edge writes, and an async active-low clear to 0.
- psum_tx holds the pointers, count, overflow, clear/reset priority and handshake logic.

## Test plan
- Reset then single word: after reset, check out_valid=0, in_ready=1, count=0, out_data=0. Push 0x1234 at one edge, then 0x1234 on out_data with out_valid=1 and count=1. Pop, then count=0 and out_valid=0.
- Fill, overflow and drain with DEPTH=4:
  - Push 0x0001..0x0004 with out_ready=0, then in_ready=0 and count=4.
  - Push 0x0005, then overflow=1 and count stays 4.
  - Drain, and 0x0001..0x0004 appear in order; 0x0005 never appears.
- Streaming with wrap-around: hold in_valid=1 and out_ready=1 for 10 cycles pushing 0x0100+i. Outputs must be 0x0100..0x0109 in order, at one word per cycle after the first word, with count constant at 1 and pointer wrap exercised twice.
- Simultaneous push/pop at boundaries:
  - Push and pop on the same edge with count=2, then count=2 afterwards.
  - Full with out_ready=1 and in_valid=1: the pop occurs and the push is rejected; count=3 and overflow=1.
- Clear priority: with count=3 and overflow=1, assert clear together with push and pop. Then count=0, out_valid=0 and overflow=0, and the pushed word is absent.
- Async reset mid-transfer: with count=2, pull reset_n low between edges. Outputs go to reset values immediately, without waiting for a clock edge, and the next push after release is the first word out.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared processing-element package.
// Holds the default psum word width and buffer depth used across the PE,
// plus the helper that sizes an occupancy counter able to hold 0..depth.
package pe_pkg;

  localparam int unsigned PSUM_WIDTH      = 16;
  localparam int unsigned PSUM_FIFO_DEPTH = 4;

  // One extra bit over the pointer width so that "full" (count == depth)
  // is representable alongside "empty" (count == 0).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/psum_fifo_mem.sv
// Register file backing the psum transmit buffer.
// Ports:
//   clk, reset_n   falling-edge write clock; async active-low clear to 0
//   we/waddr/wdata single write port
//   raddr/rdata    asynchronous read port
module psum_fifo_mem
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_WIDTH,
  parameter int unsigned DEPTH      = PSUM_FIFO_DEPTH,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/psum_tx.sv
// Transmit end of the PE partial-sum path: a small circular buffer between
// the PE datapath (producer) and the downstream consumer, valid/ready on
// both sides, all state updating on the falling clock edge.
// Ports:
//   clk, reset_n          falling-edge clock; async active-low reset
//   clear                 synchronous flush of pointers, count and overflow
//   in_valid/in_data/in_ready     producer side (in_ready = not full)
//   out_valid/out_data/out_ready  consumer side (out_valid = not empty)
//   count                 occupancy 0..DEPTH
//   overflow              sticky: a push was attempted while full
module psum_tx
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PSUM_WIDTH,
  parameter int unsigned DEPTH      = PSUM_FIFO_DEPTH,
  parameter int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          push;
  logic          pop;

  // Flags come from registered count only, so there is no path from the
  // handshake inputs to any output; a full buffer never accepts a word even
  // when the consumer pops on the same edge.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  psum_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (push & ~clear),
    .waddr   (wp),
    .wdata   (in_data),
    .raddr   (rp),
    .rdata   (out_data)
  );

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

endmodule
